cla_8bit: RTL and testbench

CLA_8BIT -- requirements
Module: cla_8bit

---
 rtl/cla_8bit.sv | 123 ++++++++++++
 tb/tb_cla_8bit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/cla_8bit.sv
// cla_8bit: 8-bit signed adder/subtractor built on a two-group carry-lookahead
// core, with the result, carry out and signed-overflow flag registered.
//
// Ports:
//   clk       in   1  clock, rising edge
//   rst       in   1  asynchronous active-high reset, clears all outputs
//   A         in   8  operand A (two's complement)
//   B         in   8  operand B (two's complement)
//   Add_ctrl  in   1  1 = A+B, 0 = A-B
//   SUM       out  8  registered result, modulo 2^8
//   C_out     out  1  registered carry out of bit 7 (subtract: 1 = no borrow)
//   v         out  1  registered signed-overflow flag
//
// Inputs are used combinationally; only the output stage holds state, so a
// new operation is taken every cycle with exactly one cycle of latency.

module cla_8bit (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] A,
   input  logic [7:0] B,
   input  logic       Add_ctrl,
   output logic [7:0] SUM,
   output logic       C_out,
   output logic       v
);

   logic [7:0] bx;
   logic       c0;
   logic [7:0] g;
   logic [7:0] p;
   logic [7:0] c;
   logic       grp_g0;
   logic       grp_p0;
   logic       grp_g1;
   logic       grp_p1;
   logic       c4;
   logic       c8;
   logic [7:0] s;
   logic       vx;

   logic [7:0] sum_q, sum_d;
   logic       cout_q, cout_d;
   logic       v_q, v_d;

   // Subtraction is A + ~B + 1: invert B and inject the +1 as carry-in.
   assign bx = Add_ctrl ? B : ~B;
   assign c0 = ~Add_ctrl;

   assign g = A & bx;
   assign p = A ^ bx;

   // Lower group (bits 3:0): carries flattened to sum-of-products of g/p/c0.
   assign c[0] = c0;
   assign c[1] = g[0]
               | (p[0] & c0);
   assign c[2] = g[1]
               | (p[1] & g[0])
               | (p[1] & p[0] & c0);
   assign c[3] = g[2]
               | (p[2] & g[1])
               | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & c0);

   assign grp_g0 = g[3]
                 | (p[3] & g[2])
                 | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0]);
   assign grp_p0 = &p[3:0];

   assign c4 = grp_g0 | (grp_p0 & c0);

   // Upper group (bits 7:4): same structure, fed by the lookahead carry c4.
   assign c[4] = c4;
   assign c[5] = g[4]
               | (p[4] & c4);
   assign c[6] = g[5]
               | (p[5] & g[4])
               | (p[5] & p[4] & c4);
   assign c[7] = g[6]
               | (p[6] & g[5])
               | (p[6] & p[5] & g[4])
               | (p[6] & p[5] & p[4] & c4);

   assign grp_g1 = g[7]
                 | (p[7] & g[6])
                 | (p[7] & p[6] & g[5])
                 | (p[7] & p[6] & p[5] & g[4]);
   assign grp_p1 = &p[7:4];

   // Carry out expanded across both groups so it does not wait on c4.
   assign c8 = grp_g1
             | (grp_p1 & grp_g0)
             | (grp_p1 & grp_p0 & c0);

   assign s  = p ^ c;

   // Signed overflow: carry into the sign bit differs from carry out of it.
   assign vx = c8 ^ c[7];

   always_comb begin
      sum_d  = s;
      cout_d = c8;
      v_d    = vx;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_q  <= 8'h00;
         cout_q <= 1'b0;
         v_q    <= 1'b0;
      end else begin
         sum_q  <= sum_d;
         cout_q <= cout_d;
         v_q    <= v_d;
      end
   end

   assign SUM   = sum_q;
   assign C_out = cout_q;
   assign v     = v_q;

endmodule

// File: tb/tb_cla_8bit.sv
// Scoreboard bench for cla_8bit: the driver pushes the arithmetic reference
// result for every operation it issues; a monitor pops one entry per clock
// and compares it to the registered outputs.

module tb_cla_8bit;

   logic       clk;
   logic       rst;
   logic [7:0] A;
   logic [7:0] B;
   logic       Add_ctrl;
   logic [7:0] SUM;
   logic       C_out;
   logic       v;

   typedef struct {
      logic [7:0] sum;
      logic       cout;
      logic       ovf;
      logic [7:0] a;
      logic [7:0] b;
      logic       add;
   } exp_t;

   exp_t exp_q[$];

   int n_tests = 0;
   int n_fail  = 0;

   cla_8bit dut (
      .clk      (clk),
      .rst      (rst),
      .A        (A),
      .B        (B),
      .Add_ctrl (Add_ctrl),
      .SUM      (SUM),
      .C_out    (C_out),
      .v        (v)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   // Reference: plain integer arithmetic on the signed/unsigned meanings.
   function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                  input logic add);
      exp_t e;
      int sa, sb, r, ua, ub;
      sa = int'($signed(a));
      sb = int'($signed(b));
      ua = int'(a);
      ub = int'(b);
      r  = add ? (sa + sb) : (sa - sb);
      e.sum  = 8'(r);
      e.ovf  = (r > 127) || (r < -128);
      e.cout = add ? ((ua + ub) > 255) : (ua >= ub);
      e.a = a;
      e.b = b;
      e.add = add;
      return e;
   endfunction

   task automatic check(input string name, input int act, input int req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic apply(input logic [7:0] a, input logic [7:0] b, input logic add);
      @(negedge clk);
      A        = a;
      B        = b;
      Add_ctrl = add;
      exp_q.push_back(model(a, b, add));
   endtask

   // Hand-derived expectations for the boundary cases; checks the model too.
   task automatic directed(input logic [7:0] a, input logic [7:0] b, input logic add,
                           input logic [7:0] sum, input logic cout, input logic ovf);
      exp_t e;
      e = model(a, b, add);
      check($sformatf("ref_sum a=%0h b=%0h add=%0b", a, b, add), int'(e.sum), int'(sum));
      check($sformatf("ref_cout a=%0h b=%0h add=%0b", a, b, add), int'(e.cout), int'(cout));
      check($sformatf("ref_v a=%0h b=%0h add=%0b", a, b, add), int'(e.ovf), int'(ovf));
      apply(a, b, add);
   endtask

   // Monitor: one result appears per rising edge; sample just after it.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (SUM !== e.sum || C_out !== e.cout || v !== e.ovf) begin
               n_fail++;
               $display("FAIL result a=%0h b=%0h add=%0b: got SUM=%0h C_out=%0b v=%0b, required SUM=%0h C_out=%0b v=%0b",
                        e.a, e.b, e.add, SUM, C_out, v, e.sum, e.cout, e.ovf);
            end
            n_tests++;
         end
      end
   end

   initial begin
      rst      = 1'b0;
      A        = 8'h55;
      B        = 8'h11;
      Add_ctrl = 1'b1;
      #1;
      rst = 1'b1;
      #1;
      check("reset_async SUM", int'(SUM), 0);
      check("reset_async C_out", int'(C_out), 0);
      check("reset_async v", int'(v), 0);
      repeat (3) @(posedge clk);
      #1;
      check("reset_held SUM", int'(SUM), 0);
      check("reset_held C_out", int'(C_out), 0);
      check("reset_held v", int'(v), 0);

      // Release, then the first edge loads 0x55+0x11.
      @(negedge clk);
      rst = 1'b0;
      exp_q.push_back(model(8'h55, 8'h11, 1'b1));
      @(posedge clk);
      #1;
      check("post_reset SUM", int'(SUM), 'h66);

      directed(8'd2,   8'd3,   1'b1, 8'h05, 1'b0, 1'b0);
      directed(8'd2,   8'd3,   1'b0, 8'hFF, 1'b0, 1'b0);
      directed(8'd127, 8'd127, 1'b1, 8'hFE, 1'b0, 1'b1);
      directed(8'd127, 8'd127, 1'b0, 8'h00, 1'b1, 1'b0);
      directed(8'h80,  8'h80,  1'b1, 8'h00, 1'b1, 1'b1);
      directed(8'h80,  8'h80,  1'b0, 8'h00, 1'b1, 1'b0);
      directed(8'h80,  8'h7F,  1'b1, 8'hFF, 1'b0, 1'b0);
      directed(8'h80,  8'h7F,  1'b0, 8'h01, 1'b1, 1'b1);
      directed(8'h81,  8'h7F,  1'b1, 8'h00, 1'b1, 1'b0);
      directed(8'h81,  8'h7F,  1'b0, 8'h02, 1'b1, 1'b1);
      directed(8'hFF,  8'hFF,  1'b1, 8'hFE, 1'b1, 1'b0);
      directed(8'hFF,  8'hFF,  1'b0, 8'h00, 1'b1, 1'b0);
      directed(8'hFE,  8'hFD,  1'b1, 8'hFB, 1'b1, 1'b0);
      directed(8'hFE,  8'hFD,  1'b0, 8'h01, 1'b1, 1'b0);
      directed(8'h3C,  8'h3C,  1'b0, 8'h00, 1'b1, 1'b0);

      // Back-to-back random operations, one per cycle.
      for (int i = 0; i < 30000; i++)
         apply(8'($urandom), 8'($urandom), 1'($urandom));

      // Mid-stream reset: the pending operation must be discarded.
      apply(8'h40, 8'h40, 1'b1);
      #2;
      rst = 1'b1;
      exp_q.delete();
      #1;
      check("midreset_async SUM", int'(SUM), 0);
      check("midreset_async C_out", int'(C_out), 0);
      check("midreset_async v", int'(v), 0);
      @(posedge clk);
      #1;
      check("midreset_held SUM", int'(SUM), 0);
      check("midreset_held v", int'(v), 0);
      @(negedge clk);
      rst = 1'b0;
      A        = 8'h80;
      B        = 8'h7F;
      Add_ctrl = 1'b0;
      exp_q.push_back(model(8'h80, 8'h7F, 1'b0));

      for (int i = 0; i < 2000; i++)
         apply(8'($urandom), 8'($urandom), 1'($urandom));

      @(posedge clk);
      #3;
      check("scoreboard_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
